led_pulse_stretcher: RTL and testbench
======================================

// Module: led_pulse_stretcher
// PURPOSE
//  Output-side counterpart of the push-button input conditioning: converts fast logic events
//  (order accepted, fill, reject, book-crossed) into human-visible LED pulses.
//  Each of NUM_CH channels stretches a rising edge on event_in into exactly HOLD_CYCLES of led_out high.
//  After the pulse comes a forced GAP_CYCLES dark interval, so repeated events appear as distinct blinks.
//  Sits between order-book status strobes and board LED pins.
// PARAMETERS
//  NUM_CH       8         number of independent channels
//  HOLD_CYCLES  5000000   LED on-time per pulse, clock cycles (>=1)
//  GAP_CYCLES   2500000   forced dark time after each pulse, clock cycles (>=0)
//  PWM_BITS     4         dimming PWM counter width (used only with LED_DIM_PWM_EN)
//  DIM_DUTY     4         PWM high slots per 2**PWM_BITS period (used only with LED_DIM_PWM_EN)
// PORTS
//  clock_in   in   1       system clock
//  reset_in   in   1       asynchronous, active-high reset
//  event_in   in   NUM_CH  event strobes/levels; rising edge = one event
//  led_out    out  NUM_CH  registered LED drive
//  busy_out   out  NUM_CH  channel is not IDLE (in ON or GAP)
//  drop_out   out  NUM_CH  1-cycle pulse: event lost because pending was already set
// BEHAVIOUR
//  - Reset (async, any time, including mid-pulse):
//    - all channels go to IDLE; led_out=0, busy_out=0, drop_out=0.
//    - Counters, pending and prev_event are cleared to 0.
//    - Consequence: an event_in held high across reset release counts as an edge on the first clock.
//  - Edge detect: edge[i] = event_in[i] & ~prev_event[i], evaluated at each posedge.
//  - Per-channel FSM states: IDLE, ON, GAP.
//    - IDLE: on edge -> ON, cnt=HOLD_CYCLES-1. led_out is high the cycle after the edge-sampling clock (1-cycle latency).
//    - ON: led high. cnt!=0 -> cnt--. cnt==0 -> GAP with cnt=GAP_CYCLES-1; if GAP_CYCLES==0, apply the GAP-exit rule now.
//    - GAP: led low. cnt!=0 -> cnt--. cnt==0 -> GAP-exit rule:
//      - pending (including an edge on that same cycle) -> ON, cnt=HOLD_CYCLES-1, pending cleared;
//      - otherwise -> IDLE.
//  - Events during ON/GAP:
//    - An edge while busy sets pending. The pulse is not extended or retriggered.
//    - An edge while pending is already set pulses drop_out for 1 cycle (registered, same latency as led_out).
//    - An edge on the final ON cycle sets pending, like any other ON cycle.
//  - ON length is exactly HOLD_CYCLES; GAP length is exactly GAP_CYCLES; back-to-back pulses are periodic.
//  - Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); no wrap is possible.
//  - Channels are fully independent; simultaneous edges on all channels are all accepted.
// CONFIGURATION
//  LED_DIM_PWM_EN defined:
//    - a shared free-running PWM_BITS counter pwm_cnt (reset 0) gates the output:
//      led_out[i] = on[i] & (pwm_cnt < DIM_DUTY).
//    - busy_out and drop_out are unaffected.
//  LED_DIM_PWM_EN undefined: led_out[i] = on[i]; no PWM logic present; PWM_BITS/DIM_DUTY ignored.
// STRUCTURE
//  - Package led_stretch_pkg: typedef enum logic[1:0] {ST_IDLE, ST_ON, ST_GAP} stretch_state_t; counter-width function.
//  - Sub-module led_stretch_channel: one FSM + counter + pending + prev_event.
//    The top generates NUM_CH instances and owns the shared PWM counter.
// TESTING (bench overrides: NUM_CH=2, HOLD_CYCLES=4, GAP_CYCLES=2, PWM_BITS=2, DIM_DUTY=1)
//  - Single pulse: event_in[0]=1 for 1 cycle -> led_out[0] high exactly 4 cycles starting next cycle; busy 6 cycles; then IDLE.
//  - Held level: event_in[0]=1 for 20 cycles -> exactly one 4-cycle pulse, no drop_out.
//  - Queued event: second edge during ON -> after 2-cycle gap, second 4-cycle pulse; third edge before that -> drop_out=1 for 1 cycle.
//  - Edge in last GAP cycle -> ON re-entered next cycle with no IDLE cycle.
//  - Async reset asserted mid-ON (between clocks) -> led_out/busy_out drop to 0 immediately; edge after release -> fresh 4-cycle pulse.
//  - LED_DIM_PWM_EN, single pulse -> led_out high only where pwm_cnt==0 (1 in 4 cycles) within the ON window.
//  - Both channels: simultaneous edges -> identical, independent pulses.

Source files
------------

// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
// Holds the per-channel state encoding and the counter-width calculation
// so the top and the channel agree on both.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } stretch_state_t;

  // Smallest width that can hold the larger of the two reload values without wrapping.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int max_cycles;
    max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED stretcher channel.
// A rising edge on event_in lights the LED for HOLD_CYCLES and then forces a GAP_CYCLES
// dark interval. One further event arriving meanwhile is remembered and replayed once
// the gap ends. Any event beyond that is reported on drop.
module led_stretch_channel
  import led_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic event_in,
  output logic led_on,
  output logic busy,
  output logic drop
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  stretch_state_t  state;
  logic [CW-1:0]   cnt;
  logic            pending;
  logic            prev_event;
  logic            edge_seen;
  logic            exit_now;
  logic            take_next;

  // Edge detect and end-of-pulse decision.
  // A zero-length gap makes the last ON cycle the exit point.
  always_comb begin
    edge_seen = event_in & ~prev_event;
    exit_now  = 1'b0;
    if (state == ST_GAP && cnt == '0) begin
      exit_now = 1'b1;
    end else if (state == ST_ON && cnt == '0 && GAP_CYCLES == 0) begin
      exit_now = 1'b1;
    end
    take_next = pending | edge_seen;
  end

  // Channel FSM. The LED, busy and drop outputs are registered alongside the state.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      prev_event <= 1'b0;
      led_on     <= 1'b0;
      busy       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      prev_event <= event_in;
      drop       <= (state != ST_IDLE) && edge_seen && pending;
      if (state == ST_IDLE) begin
        if (edge_seen) begin
          state  <= ST_ON;
          cnt    <= HOLD_LOAD;
          led_on <= 1'b1;
          busy   <= 1'b1;
        end
      end else if (exit_now) begin
        pending <= 1'b0;
        if (take_next) begin
          state  <= ST_ON;
          cnt    <= HOLD_LOAD;
          led_on <= 1'b1;
          busy   <= 1'b1;
        end else begin
          state  <= ST_IDLE;
          cnt    <= '0;
          led_on <= 1'b0;
          busy   <= 1'b0;
        end
      end else begin
        if (edge_seen) begin
          pending <= 1'b1;
        end
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          state  <= ST_GAP;
          cnt    <= GAP_LOAD;
          led_on <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns fast order-book status strobes into human-visible LED blinks, one channel per event type.
// Optional feature macro: LED_DIM_PWM_EN.
// When defined, a shared free-running PWM counter dims every LED.
// busy_out and drop_out are not dimmed.
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int PWM_BITS    = 4,
  parameter int DIM_DUTY    = 4
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [NUM_CH-1:0] event_in,
  output logic [NUM_CH-1:0] led_out,
  output logic [NUM_CH-1:0] busy_out,
  output logic [NUM_CH-1:0] drop_out
);

  logic [NUM_CH-1:0] on_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_stretch_channel #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_channel (
      .clock_in(clock_in),
      .reset_in(reset_in),
      .event_in(event_in[i]),
      .led_on  (on_vec[i]),
      .busy    (busy_out[i]),
      .drop    (drop_out[i])
    );
  end

`ifdef LED_DIM_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_gate;

  // Free-running dimming counter shared by all channels.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // The comparison is one bit wider so that a full-duty setting stays always-on.
  always_comb begin
    pwm_gate = ({1'b0, pwm_cnt} < (PWM_BITS + 1)'(DIM_DUTY));
    led_out  = on_vec & {NUM_CH{pwm_gate}};
  end
`else
  assign led_out = on_vec;
`endif

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher with two small channels.
// Expected outputs come from a pulse-schedule model.
// The model tracks when each pulse started and compares cycle numbers against that start.
// Honours LED_DIM_PWM_EN when it is defined for the build.
module tb_led_pulse_stretcher;

  localparam int NUM_CH   = 2;
  localparam int HOLD     = 4;
  localparam int GAP      = 2;
  localparam int PWM_BITS = 2;
  localparam int DIM_DUTY = 1;

  logic              clock_in = 1'b0;
  logic              reset_in = 1'b1;
  logic [NUM_CH-1:0] event_in = '0;
  logic [NUM_CH-1:0] led_out;
  logic [NUM_CH-1:0] busy_out;
  logic [NUM_CH-1:0] drop_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic              m_active [NUM_CH];
  int                m_start  [NUM_CH];
  logic              m_pend   [NUM_CH];
  logic              m_prev   [NUM_CH];
  logic [NUM_CH-1:0] m_on;
  logic [NUM_CH-1:0] m_busy;
  logic [NUM_CH-1:0] m_drop;

  typedef struct {
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] on;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] drop;
  } vec_t;

  vec_t tbl [8];

  led_pulse_stretcher #(
    .NUM_CH     (NUM_CH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PWM_BITS   (PWM_BITS),
    .DIM_DUTY   (DIM_DUTY)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .event_in(event_in),
    .led_out (led_out),
    .busy_out(busy_out),
    .drop_out(drop_out)
  );

  // 100 MHz style free-running clock
  always #5 clock_in = ~clock_in;

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVec(input string name, input logic [NUM_CH-1:0] act,
                            input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compareInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected LED = expected on-window, gated by the dimming slot when dimming is built in
  task automatic checkOutput(input string name, input logic [NUM_CH-1:0] exp_on,
                             input logic [NUM_CH-1:0] exp_busy,
                             input logic [NUM_CH-1:0] exp_drop);
    logic [NUM_CH-1:0] gate;
`ifdef LED_DIM_PWM_EN
    gate = ((cyc % (1 << PWM_BITS)) < DIM_DUTY) ? '1 : '0;
`else
    gate = '1;
`endif
    compareVec({name, " led"}, led_out, exp_on & gate);
    compareVec({name, " busy"}, busy_out, exp_busy);
    compareVec({name, " drop"}, drop_out, exp_drop);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_active[i] = 1'b0;
      m_start[i]  = 0;
      m_pend[i]   = 1'b0;
      m_prev[i]   = 1'b0;
    end
    m_on   = '0;
    m_busy = '0;
    m_drop = '0;
    cyc    = 0;
  endtask

  // A pulse started at clock s is lit for clocks s..s+HOLD-1 and dark until s+HOLD+GAP.
  // At clock s+HOLD+GAP a remembered or simultaneous event restarts the pulse.
  task automatic modelStep(input logic [NUM_CH-1:0] ev);
    logic e;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      e         = ev[i] && !m_prev[i];
      m_prev[i] = ev[i];
      m_drop[i] = 1'b0;
      if (m_active[i] && cyc == m_start[i] + HOLD + GAP) begin
        if (m_pend[i] || e) begin
          m_drop[i]  = m_pend[i] && e;
          m_start[i] = cyc;
          m_pend[i]  = 1'b0;
        end else begin
          m_active[i] = 1'b0;
        end
      end else if (m_active[i]) begin
        if (e) begin
          if (m_pend[i]) m_drop[i] = 1'b1;
          else m_pend[i] = 1'b1;
        end
      end else if (e) begin
        m_active[i] = 1'b1;
        m_start[i]  = cyc;
      end
      m_on[i]   = m_active[i] && (cyc < m_start[i] + HOLD);
      m_busy[i] = m_active[i];
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] ev);
    event_in = ev;
    @(posedge clock_in);
    #1;
    modelStep(ev);
    checkOutput("model", m_on, m_busy, m_drop);
  endtask

  // Reset asserts between clock edges; outputs must clear without waiting for a clock
  task automatic doReset(input logic [NUM_CH-1:0] hold_ev);
    reset_in = 1'b1;
    event_in = hold_ev;
    modelReset();
    #1;
    checkOutput("async_reset", '0, '0, '0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    reset_in = 1'b0;
  endtask

  int busy_cnt0;
  int busy_cnt1;
  int drop_cnt;
  logic [NUM_CH-1:0] rnd_ev;

  initial begin
    tbl[0] = '{ev: 2'b01, on: 2'b01, busy: 2'b01, drop: 2'b00};
    tbl[1] = '{ev: 2'b00, on: 2'b01, busy: 2'b01, drop: 2'b00};
    tbl[2] = '{ev: 2'b00, on: 2'b01, busy: 2'b01, drop: 2'b00};
    tbl[3] = '{ev: 2'b00, on: 2'b01, busy: 2'b01, drop: 2'b00};
    tbl[4] = '{ev: 2'b00, on: 2'b00, busy: 2'b01, drop: 2'b00};
    tbl[5] = '{ev: 2'b00, on: 2'b00, busy: 2'b01, drop: 2'b00};
    tbl[6] = '{ev: 2'b00, on: 2'b00, busy: 2'b00, drop: 2'b00};
    tbl[7] = '{ev: 2'b00, on: 2'b00, busy: 2'b00, drop: 2'b00};

    doReset('0);

    $display("[TB] single pulse");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].ev);
      checkOutput("single_pulse", tbl[i].on, tbl[i].busy, tbl[i].drop);
    end

    $display("[TB] held level");
    doReset('0);
    busy_cnt0 = 0;
    drop_cnt  = 0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus((i < 20) ? 2'b01 : 2'b00);
      busy_cnt0 += int'(busy_out[0]);
      drop_cnt  += int'(drop_out[0]);
    end
    compareInt("held_busy_cycles", busy_cnt0, HOLD + GAP);
    compareInt("held_drops", drop_cnt, 0);

    $display("[TB] queued event and drop");
    doReset('0);
    busy_cnt0 = 0;
    drop_cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i == 0 || i == 2 || i == 4) ? 2'b01 : 2'b00);
      busy_cnt0 += int'(busy_out[0]);
      drop_cnt  += int'(drop_out[0]);
    end
    compareInt("queued_busy_cycles", busy_cnt0, 2 * (HOLD + GAP));
    compareInt("queued_drops", drop_cnt, 1);

    $display("[TB] edge in last gap cycle");
    doReset('0);
    busy_cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i == 0 || i == HOLD + GAP) ? 2'b01 : 2'b00);
      busy_cnt0 += int'(busy_out[0]);
      if (i == HOLD + GAP) checkOutput("regap_restart", 2'b01, 2'b01, 2'b00);
    end
    compareInt("regap_busy_cycles", busy_cnt0, 2 * (HOLD + GAP));

    $display("[TB] reset mid-pulse, event held across release");
    doReset('0);
    applyStimulus(2'b01);
    applyStimulus(2'b00);
    #2;
    doReset(2'b01);
    applyStimulus(2'b01);
    checkOutput("post_reset_first", 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 8; i++) applyStimulus(2'b00);

    $display("[TB] simultaneous edges");
    doReset('0);
    busy_cnt0 = 0;
    busy_cnt1 = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i == 0) ? 2'b11 : 2'b00);
      busy_cnt0 += int'(busy_out[0]);
      busy_cnt1 += int'(busy_out[1]);
    end
    compareInt("both_busy_ch0", busy_cnt0, HOLD + GAP);
    compareInt("both_busy_ch1", busy_cnt1, HOLD + GAP);

    $display("[TB] randomized traffic");
    doReset('0);
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NUM_CH; b++) rnd_ev[b] = ($urandom_range(0, 99) < 35);
      applyStimulus(rnd_ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
